// File: rtl/fifo_sync_prog.sv
// rtl/fifo_sync_prog.sv - single-clock FIFO with registered status flags and programmable thresholds
// Define FIFO_SYNC_ERR_EN to enable sticky overflow/underflow tracking.
module fifo_sync_prog #(
  parameter int DWIDTH   = 8,
  parameter int ASIZE    = 4,
  parameter int AF_LEVEL = (1 << ASIZE) - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              winc,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              rinc,
  output logic [DWIDTH-1:0] rdata,
  output logic              rvalid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ASIZE:0]    count,
  output logic              wen,
  output logic              ren,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] AF_THR = (ASIZE+1)'(AF_LEVEL);
  localparam logic [ASIZE:0] AE_THR = (ASIZE+1)'(AE_LEVEL);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [ASIZE:0]    wptr, rptr;
  logic [ASIZE:0]    wptr_next, rptr_next, count_next;

  // A full FIFO still accepts a write when a read frees a slot in the same cycle.
  always_comb begin
    wen        = winc & (~full | rinc);
    ren        = rinc & ~empty;
    wptr_next  = wptr + {{ASIZE{1'b0}}, wen};
    rptr_next  = rptr + {{ASIZE{1'b0}}, ren};
    count_next = wptr_next - rptr_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= (AF_LEVEL == 0);
      almost_empty <= 1'b1;
      rvalid       <= 1'b0;
      rdata        <= '0;
    end else begin
      wptr         <= wptr_next;
      rptr         <= rptr_next;
      count        <= count_next;
      empty        <= (wptr_next == rptr_next);
      full         <= (wptr_next[ASIZE-1:0] == rptr_next[ASIZE-1:0]) &&
                      (wptr_next[ASIZE] != rptr_next[ASIZE]);
      almost_full  <= (count_next >= AF_THR);
      almost_empty <= (count_next <= AE_THR);
      rvalid       <= ren;
      if (ren) rdata <= mem[rptr[ASIZE-1:0]];
    end
  end

  // Storage is not cleared on reset; the pointers alone define the contents.
  always_ff @(posedge clk) begin
    if (wen && !rst) mem[wptr[ASIZE-1:0]] <= wdata;
  end

`ifdef FIFO_SYNC_ERR_EN
  // A new error outranks a clear arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (winc && !wen)  overflow <= 1'b1;
      else if (err_clr)  overflow <= 1'b0;
      if (rinc && !ren)  underflow <= 1'b1;
      else if (err_clr)  underflow <= 1'b0;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule
